lpm_fifo_rd_arb: RTL and testbench

Round-robin read scheduler that shares one downstream consumer between up to eight FIFO read ports (lpm_fifo_dc read side, lpm_showahead = "OFF", all read ports clocked by this block's clock). It issues single-cycle rdreq pulses to the granted FIFO and captures the returned word. It presents the word on a valid/ready output with source-port tag and end-of-burst marker. Bursts per grant are bounded so no port starves.

---
 rtl/lpm_fifo_rd_arb.sv | 167 ++++++++++++++++
 tb/tb_lpm_fifo_rd_arb.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_fifo_rd_arb.sv
// rtl/lpm_fifo_rd_arb.sv - round-robin read scheduler sharing one consumer between FIFO read ports
//
// Ports:
//   clock      single clock for the FIFO read ports and the consumer
//   sclr       synchronous active-high clear
//   port_en    per-port enable; a disabled port is never granted
//   rdempty    FIFO empty flags (registered in the FIFO, valid one cycle after rdreq)
//   q_in       FIFO q buses, port k at [k*lpm_width +: lpm_width]
//   rdreq      single-cycle read pulse to the granted FIFO (one-hot or zero)
//   out_data   captured word, out_valid/out_ready handshake
//   out_port   source port index of out_data
//   out_last   last word of the current grant
//   busy       a grant is in flight
module lpm_fifo_rd_arb #(
    parameter int lpm_width  = 8,
    parameter int lpm_widthu = 4,
    parameter int num_ports  = 4,
    parameter int max_burst  = 4
) (
    input  logic                           clock,
    input  logic                           sclr,
    input  logic [num_ports-1:0]           port_en,
    input  logic [num_ports-1:0]           rdempty,
    input  logic [num_ports*lpm_width-1:0] q_in,
    output logic [num_ports-1:0]           rdreq,
    output logic [lpm_width-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2:0]                     out_port,
    output logic                           out_last,
    output logic                           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [2:0] last_port     = 3'(num_ports - 1);
    localparam logic [7:0] burst_max_cnt = 8'(max_burst - 1);

    if (num_ports < 1 || num_ports > 8) begin : g_bad_num_ports
        $error("lpm_fifo_rd_arb: num_ports must be 1..8");
    end
    if (max_burst < 1 || max_burst > 255) begin : g_bad_max_burst
        $error("lpm_fifo_rd_arb: max_burst must be 1..255");
    end
    if (lpm_width < 1 || lpm_widthu < 1) begin : g_bad_width
        $error("lpm_fifo_rd_arb: lpm_width and lpm_widthu must be positive");
    end

    logic [1:0]           state;
    logic [2:0]           grant;
    logic [2:0]           last_grant;
    logic [7:0]           burst_cnt;
    logic [num_ports-1:0] eligible;

    logic                 found_hi;
    logic                 found_lo;
    logic [2:0]           hi_idx;
    logic [2:0]           lo_idx;
    logic                 any_elig;
    logic [2:0]           next_grant;

    logic [lpm_width-1:0] sel_q;
    logic                 sel_empty;
    logic                 sel_en;

    assign eligible = port_en & ~rdempty;

    // Round-robin search starting after last_grant: the lowest eligible index
    // above last_grant wins; if there is none, wrap to the lowest eligible index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int k = num_ports - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                found_lo = 1'b1;
                lo_idx   = 3'(k);
                if (3'(k) > last_grant) begin
                    found_hi = 1'b1;
                    hi_idx   = 3'(k);
                end
            end
        end
        any_elig   = found_lo;
        next_grant = found_hi ? hi_idx : lo_idx;
    end

    // Per-port views of the granted port, built with constant indices so an
    // out-of-range grant can never select a nonexistent lane.
    always_comb begin
        sel_q     = '0;
        sel_empty = 1'b1;
        sel_en    = 1'b0;
        for (int k = 0; k < num_ports; k++) begin
            if (grant == 3'(k)) begin
                sel_q     = q_in[k*lpm_width +: lpm_width];
                sel_empty = rdempty[k];
                sel_en    = port_en[k];
            end
        end
    end

    // The read pulse is decoded from the state so it lasts exactly one cycle.
    always_comb begin
        rdreq = '0;
        for (int k = 0; k < num_ports; k++) begin
            rdreq[k] = (state == READ) && (grant == 3'(k));
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (sclr) begin
            state      <= IDLE;
            grant      <= 3'd0;
            last_grant <= last_port;
            burst_cnt  <= 8'd0;
            out_data   <= '0;
            out_port   <= 3'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant     <= next_grant;
                        burst_cnt <= 8'd0;
                        state     <= READ;
                    end
                end
                READ: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // rdempty here already reflects the read just issued, so an
                    // empty FIFO or a dropped enable closes the burst on this word.
                    out_data  <= sel_q;
                    out_port  <= grant;
                    out_valid <= 1'b1;
                    out_last  <= (burst_cnt == burst_max_cnt) || sel_empty || !sel_en;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                            state     <= READ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpm_fifo_rd_arb.sv
// tb/tb_lpm_fifo_rd_arb.sv - self-checking bench for lpm_fifo_rd_arb
module tb_lpm_fifo_rd_arb;

    localparam int W  = 8;
    localparam int NP = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] port;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [NP-1:0]      en;
        logic [NP-1:0][7:0] base;
        logic [NP-1:0][3:0] cnt;
        logic [3:0]         n_exp;
        beat_t [7:0]        exp;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              sclr = 1'b1;
    logic [NP-1:0]     port_en = '0;
    logic [NP-1:0]     rdempty = '1;
    logic [NP*W-1:0]   q_in;
    logic [NP-1:0]     rdreq;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2:0]        out_port;
    logic              out_last;
    logic              busy;

    logic              s1_en = 1'b1;
    logic              s1_empty = 1'b1;
    logic [W-1:0]      s1_q = '0;
    logic              s1_rdreq;
    logic [W-1:0]      s1_data;
    logic              s1_valid;
    logic              s1_ready = 1'b1;
    logic [2:0]        s1_port;
    logic              s1_last;
    logic              s1_busy;

    lpm_fifo_rd_arb #(.lpm_width(W), .lpm_widthu(4), .num_ports(NP), .max_burst(MB)) dut (
        .clock(clock), .sclr(sclr), .port_en(port_en), .rdempty(rdempty), .q_in(q_in),
        .rdreq(rdreq), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_port(out_port), .out_last(out_last), .busy(busy)
    );

    lpm_fifo_rd_arb #(.lpm_width(W), .lpm_widthu(4), .num_ports(1), .max_burst(1)) dut1 (
        .clock(clock), .sclr(sclr), .port_en(s1_en), .rdempty(s1_empty), .q_in(s1_q),
        .rdreq(s1_rdreq), .out_data(s1_data), .out_valid(s1_valid), .out_ready(s1_ready),
        .out_port(s1_port), .out_last(s1_last), .busy(s1_busy)
    );

    int checks = 0;
    int fails  = 0;
    int cyc_cnt = 0;
    int underflow = 0;
    int ready_mode = 2;

    // Show-ahead-off FIFO read sides: q and rdempty are registered on rdreq.
    logic [W-1:0] fq [NP][$];
    logic [W-1:0] qreg [NP];
    int           rdcnt [NP];
    logic [W-1:0] fq1 [$];

    beat_t got [$];
    int    got_cyc [$];
    beat_t got1 [$];
    int    got1_cyc [$];
    beat_t exp_q [$];

    logic [7:0] stage [NP][8];
    int         stage_n [NP];
    vec_t       tbl [4];

    for (genvar g = 0; g < NP; g++) begin : g_q
        assign q_in[g*W +: W] = qreg[g];
    end

    initial begin
        for (int k = 0; k < NP; k++) begin
            qreg[k]  = '0;
            rdcnt[k] = 0;
        end
    end

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clock) begin
        for (int k = 0; k < NP; k++) begin
            if (rdreq[k]) begin
                rdcnt[k] = rdcnt[k] + 1;
                if (fq[k].size() == 0) underflow = underflow + 1;
                else qreg[k] <= fq[k].pop_front();
            end
            rdempty[k] <= (fq[k].size() == 0);
        end
        if (s1_rdreq) begin
            if (fq1.size() == 0) underflow = underflow + 1;
            else s1_q <= fq1.pop_front();
        end
        s1_empty <= (fq1.size() == 0);
    end

    always @(posedge clock) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic [2:0] p, input logic l);
        beat_t b;
        b.data = d;
        b.port = p;
        b.last = l;
        return b;
    endfunction

    // Output monitor: records accepted beats and checks handshake invariants.
    bit    pv = 0;
    bit    pacc = 0;
    beat_t pb;
    beat_t mon_b;
    always @(negedge clock) begin
        mon_b = mk(out_data, out_port, out_last);
        if (sclr) begin
            pv = 0;
        end else begin
            if (pv && !pacc) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_stable", 32'(mon_b), 32'(pb));
            end
            chk("rdreq_onehot0", 32'($onehot0(rdreq)), 1);
            if (out_valid) chk("rdreq_while_valid", 32'(rdreq), 0);
            if (out_valid && out_ready) begin
                got.push_back(mon_b);
                got_cyc.push_back(cyc_cnt);
            end
            pv   = out_valid;
            pb   = mon_b;
            pacc = out_valid && out_ready;
            if (s1_valid && s1_ready) begin
                got1.push_back(mk(s1_data, s1_port, s1_last));
                got1_cyc.push_back(cyc_cnt);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_stage();
        for (int k = 0; k < NP; k++) stage_n[k] = 0;
    endtask

    task automatic start_scenario(input logic [NP-1:0] en);
        sclr = 1'b1;
        cyc();
        got.delete();
        got_cyc.delete();
        for (int k = 0; k < NP; k++) begin
            fq[k].delete();
            rdcnt[k] = 0;
            for (int i = 0; i < stage_n[k]; i++) fq[k].push_back(stage[k][i]);
        end
        port_en = en;
        cyc(2);
        sclr = 1'b0;
    endtask

    task automatic wait_drain(input int n, input string name);
        int t;
        t = 0;
        while (!(got.size() >= n && !busy) && t < 3000) begin
            cyc();
            t++;
        end
        chk({name, "_drain"}, 32'(t < 3000), 1);
        cyc(6);
    endtask

    task automatic cmp_beats(input string name);
        int pc [NP];
        chk({name, "_nbeats"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
        for (int k = 0; k < NP; k++) pc[k] = 0;
        foreach (exp_q[i]) pc[exp_q[i].port] = pc[exp_q[i].port] + 1;
        for (int k = 0; k < NP; k++)
            chk($sformatf("%s_rdreq_p%0d", name, k), rdcnt[k], pc[k]);
    endtask

    // Reference: repeatedly pick the next non-empty enabled port after the
    // previous winner and drain up to MB words from it.
    function automatic void model_build(input logic [NP-1:0] en);
        int  rem [NP];
        int  pos [NP];
        int  last;
        int  p;
        int  b;
        bit  done;
        exp_q.delete();
        for (int k = 0; k < NP; k++) begin
            rem[k] = en[k] ? stage_n[k] : 0;
            pos[k] = 0;
        end
        last = NP - 1;
        done = 0;
        for (int it = 0; it < 64 && !done; it++) begin
            p = -1;
            for (int off = NP; off >= 1; off--)
                if (rem[(last + off) % NP] > 0) p = (last + off) % NP;
            if (p < 0) begin
                done = 1;
            end else begin
                b = 0;
                while (b < MB && rem[p] > 0) begin
                    exp_q.push_back(mk(stage[p][pos[p]], 3'(p), (b == MB - 1) || (rem[p] == 1)));
                    pos[p]++;
                    rem[p]--;
                    b++;
                end
                last = p;
            end
        end
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int l0;
        int nrd;
        logic [NP-1:0] ren;

        // Table: round robin, burst cap, disabled port, empty port.
        tbl[0] = '0;
        tbl[0].en = 4'b1111;
        tbl[0].base = {8'h43, 8'h32, 8'h21, 8'h10};
        tbl[0].cnt = {4'd1, 4'd1, 4'd1, 4'd1};
        tbl[0].n_exp = 4;
        tbl[0].exp[0] = mk(8'h10, 3'd0, 1'b1);
        tbl[0].exp[1] = mk(8'h21, 3'd1, 1'b1);
        tbl[0].exp[2] = mk(8'h32, 3'd2, 1'b1);
        tbl[0].exp[3] = mk(8'h43, 3'd3, 1'b1);

        tbl[1] = '0;
        tbl[1].en = 4'b1111;
        tbl[1].base = {8'hB0, 8'h00, 8'hA0, 8'h00};
        tbl[1].cnt = {4'd2, 4'd0, 4'd6, 4'd0};
        tbl[1].n_exp = 8;
        tbl[1].exp[0] = mk(8'hA0, 3'd1, 1'b0);
        tbl[1].exp[1] = mk(8'hA1, 3'd1, 1'b0);
        tbl[1].exp[2] = mk(8'hA2, 3'd1, 1'b0);
        tbl[1].exp[3] = mk(8'hA3, 3'd1, 1'b1);
        tbl[1].exp[4] = mk(8'hB0, 3'd3, 1'b0);
        tbl[1].exp[5] = mk(8'hB1, 3'd3, 1'b1);
        tbl[1].exp[6] = mk(8'hA4, 3'd1, 1'b0);
        tbl[1].exp[7] = mk(8'hA5, 3'd1, 1'b1);

        tbl[2] = '0;
        tbl[2].en = 4'b1011;
        tbl[2].base = {8'h43, 8'h32, 8'h21, 8'h10};
        tbl[2].cnt = {4'd1, 4'd1, 4'd1, 4'd1};
        tbl[2].n_exp = 3;
        tbl[2].exp[0] = mk(8'h10, 3'd0, 1'b1);
        tbl[2].exp[1] = mk(8'h21, 3'd1, 1'b1);
        tbl[2].exp[2] = mk(8'h43, 3'd3, 1'b1);

        tbl[3] = '0;
        tbl[3].en = 4'b1111;
        tbl[3].base = {8'h43, 8'h32, 8'h21, 8'h10};
        tbl[3].cnt = {4'd1, 4'd0, 4'd3, 4'd2};
        tbl[3].n_exp = 6;
        tbl[3].exp[0] = mk(8'h10, 3'd0, 1'b0);
        tbl[3].exp[1] = mk(8'h11, 3'd0, 1'b1);
        tbl[3].exp[2] = mk(8'h21, 3'd1, 1'b0);
        tbl[3].exp[3] = mk(8'h22, 3'd1, 1'b0);
        tbl[3].exp[4] = mk(8'h23, 3'd1, 1'b1);
        tbl[3].exp[5] = mk(8'h43, 3'd3, 1'b1);

        // Reset state.
        sclr = 1'b1;
        cyc(3);
        chk("rst_rdreq", 32'(rdreq), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_port", 32'(out_port), 0);
        chk("rst_busy", 32'(busy), 0);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < NP; k++) begin
                stage_n[k] = int'(tbl[v].cnt[k]);
                for (int i = 0; i < 8; i++) stage[k][i] = tbl[v].base[k] + 8'(i);
            end
            exp_q.delete();
            for (int i = 0; i < int'(tbl[v].n_exp); i++) exp_q.push_back(tbl[v].exp[i]);
            ready_mode = 0;
            start_scenario(tbl[v].en);
            wait_drain(exp_q.size(), $sformatf("vec%0d", v));
            cmp_beats($sformatf("vec%0d", v));
        end

        // Reset while a word is held: word dropped, arbitration restarts at port 0.
        clear_stage();
        stage_n[1] = 1;
        stage[1][0] = 8'h5A;
        ready_mode = 0;
        start_scenario(4'b1111);
        wait_drain(1, "pre_rst");
        ready_mode = 2;
        fq[1].push_back(8'h5B);
        t = 0;
        while (!out_valid && t < 50) begin cyc(); t++; end
        chk("hold_rst_valid_seen", 32'(out_valid), 1);
        chk("hold_rst_data", 32'(out_data), 32'h5B);
        sclr = 1'b1;
        cyc();
        chk("hold_rst_out_valid", 32'(out_valid), 0);
        chk("hold_rst_rdreq", 32'(rdreq), 0);
        chk("hold_rst_busy", 32'(busy), 0);
        got.delete();
        for (int k = 0; k < NP; k++) rdcnt[k] = 0;
        fq[0].push_back(8'h01);
        fq[2].push_back(8'h02);
        ready_mode = 0;
        cyc(2);
        sclr = 1'b0;
        wait_drain(2, "post_rst");
        exp_q.delete();
        exp_q.push_back(mk(8'h01, 3'd0, 1'b1));
        exp_q.push_back(mk(8'h02, 3'd2, 1'b1));
        cmp_beats("post_rst");

        // Backpressure: word held 10 cycles, then accepted once, next rdreq one cycle later.
        clear_stage();
        stage_n[0] = 2;
        stage[0][0] = 8'hC0;
        stage[0][1] = 8'hC1;
        ready_mode = 2;
        start_scenario(4'b0001);
        t = 0;
        while (!out_valid && t < 50) begin cyc(); t++; end
        chk("bp_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'hC0);
            chk("bp_rdreq", 32'(rdreq), 0);
        end
        ready_mode = 0;
        cyc();
        chk("bp_next_rdreq", 32'(rdreq), 32'b0001);
        chk("bp_accept_once", got.size(), 1);
        wait_drain(2, "bp");
        exp_q.delete();
        exp_q.push_back(mk(8'hC0, 3'd0, 1'b0));
        exp_q.push_back(mk(8'hC1, 3'd0, 1'b1));
        cmp_beats("bp");

        // port_en dropped mid-burst: the word being loaded closes the burst.
        clear_stage();
        stage_n[0] = 6;
        for (int i = 0; i < 6; i++) stage[0][i] = 8'hD0 + 8'(i);
        ready_mode = 0;
        start_scenario(4'b0001);
        nrd = 0;
        t = 0;
        while (nrd < 2 && t < 100) begin
            cyc();
            t++;
            if (rdreq[0]) nrd++;
        end
        port_en = 4'b0000;
        chk("en_drop_second_read", nrd, 2);
        t = 0;
        while (!(got.size() >= 2 && !busy) && t < 100) begin cyc(); t++; end
        cyc(6);
        chk("en_drop_nbeats", got.size(), 2);
        chk("en_drop_reads", rdcnt[0], 2);
        if (got.size() >= 2) chk("en_drop_last_word", 32'(got[1]), 32'(mk(8'hD1, 3'd0, 1'b1)));
        port_en = 4'b0001;
        wait_drain(6, "en_drop");
        model_build(4'b0001);
        exp_q[1].last = 1'b1;
        for (int i = 2; i < 6; i++) exp_q[i].last = (i == 5);
        cmp_beats("en_drop");

        // Single port, max_burst 1: 4 cycles per word, first valid 3 cycles after eligibility.
        got1.delete();
        got1_cyc.delete();
        l0 = cyc_cnt;
        fq1.push_back(8'hE0);
        fq1.push_back(8'hE1);
        fq1.push_back(8'hE2);
        t = 0;
        while (got1.size() < 3 && t < 100) begin cyc(); t++; end
        cyc(6);
        chk("p1_nbeats", got1.size(), 3);
        for (int i = 0; i < got1.size() && i < 3; i++) begin
            chk($sformatf("p1_beat%0d", i), 32'(got1[i]), 32'(mk(8'hE0 + 8'(i), 3'd0, 1'b1)));
            if (i == 0) chk("p1_latency", got1_cyc[0] - l0, 4);
            else chk($sformatf("p1_gap%0d", i), got1_cyc[i] - got1_cyc[i-1], 4);
        end

        // Randomized traffic against the reference model.
        for (int r = 0; r < 30; r++) begin
            ren = NP'($urandom_range(0, 15));
            for (int k = 0; k < NP; k++) begin
                stage_n[k] = $urandom_range(0, 8);
                for (int i = 0; i < 8; i++) stage[k][i] = 8'($urandom);
            end
            model_build(ren);
            ready_mode = 1;
            start_scenario(ren);
            wait_drain(exp_q.size(), $sformatf("rnd%0d", r));
            cmp_beats($sformatf("rnd%0d", r));
        end

        chk("fifo_underflow", underflow, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
